// File: rtl/test_st_source.sv
// -----------------------------------------------------------------------------
// test_st_source
//
// Avalon-ST pattern generator. It is the transmit-side counterpart to
// test_st_sink. It feeds the msgdma stream-sink port so that the DMA writes
// known counting data into F2H SDRAM. The HPS then checks memory against the
// same formula.
//
// A start pulse in IDLE latches num_beats and seed and emits one packet.
// 32-bit word j of beat k is (seed + k*W + j) mod 2^32, where W = DATA_WIDTH/32.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous reset, active-low
//   start          in   1-cycle start pulse, ignored while busy
//   num_beats      in   beats in the packet (0 -> done pulse only)
//   seed           in   base value of the counting pattern
//   st_data        out  Avalon-ST data
//   valid          out  Avalon-ST valid
//   ready          in   Avalon-ST ready (readyLatency 0)
//   startofpacket  out  high on beat 0 only
//   endofpacket    out  high on the last beat only
//   busy           out  high in SEND and FIN
//   done           out  1-cycle pulse after the packet completes
//   beats_sent     out  accepted beats in the current/last packet
//
// Configuration macro: ST_SRC_BUBBLE_EN
//   When defined, valid drops for one cycle after the handshake of every beat
//   with k%4==3 that is not the last beat.
// -----------------------------------------------------------------------------
module test_st_source #(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_beats,
    input  logic [31:0]           seed,
    output logic [DATA_WIDTH-1:0] st_data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  startofpacket,
    output logic                  endofpacket,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      beats_sent
);

    localparam int W = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_num_beats;
    logic [31:0]           r_seed;
    logic [CNT_W-1:0]      r_k;
    logic [CNT_W-1:0]      r_beats_sent;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_busy;
    logic                  r_done;

    logic [CNT_W-1:0]      w_k_next;
    logic                  w_last;
    logic                  w_next_last;

    // Builds the whole beat for index k from the latched seed.
    function automatic logic [DATA_WIDTH-1:0] f_pattern(
        input logic [31:0]      i_seed,
        input logic [CNT_W-1:0] i_k
    );
        logic [DATA_WIDTH-1:0] v_beat;
        logic [31:0]           v_base;
        v_base = i_seed + (32'(i_k) * 32'(W));
        v_beat = {DATA_WIDTH{1'b0}};
        for (int j = 0; j < W; j++) begin
            v_beat[32*j +: 32] = v_base + 32'(j);
        end
        return v_beat;
    endfunction

    assign w_k_next    = r_k + CNT_W'(1);
    assign w_last      = (r_k == (r_num_beats - CNT_W'(1)));
    assign w_next_last = (w_k_next == (r_num_beats - CNT_W'(1)));

    // Packet FSM with all stream and status outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_num_beats  <= {CNT_W{1'b0}};
            r_seed       <= 32'd0;
            r_k          <= {CNT_W{1'b0}};
            r_beats_sent <= {CNT_W{1'b0}};
            r_data       <= {DATA_WIDTH{1'b0}};
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_num_beats  <= num_beats;
                        r_seed       <= seed;
                        r_k          <= {CNT_W{1'b0}};
                        r_beats_sent <= {CNT_W{1'b0}};
                        r_busy       <= 1'b1;
                        if (num_beats != {CNT_W{1'b0}}) begin
                            r_state <= ST_SEND;
                            r_valid <= 1'b1;
                            r_data  <= f_pattern(seed, {CNT_W{1'b0}});
                            r_sop   <= 1'b1;
                            r_eop   <= (num_beats == CNT_W'(1));
                        end else begin
                            // Empty packet: straight to the done pulse.
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_SEND: begin
                    if (r_valid) begin
                        if (ready) begin
                            r_beats_sent <= r_beats_sent + CNT_W'(1);
                            r_sop        <= 1'b0;
                            if (w_last) begin
                                r_state <= ST_FIN;
                                r_valid <= 1'b0;
                                r_eop   <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_k    <= w_k_next;
                                r_data <= f_pattern(r_seed, w_k_next);
`ifdef ST_SRC_BUBBLE_EN
                                // Idle cycle after every fourth beat. The next
                                // beat's data is already loaded while valid is low.
                                if (r_k[1:0] == 2'b11) begin
                                    r_valid <= 1'b0;
                                    r_eop   <= 1'b0;
                                end else begin
                                    r_valid <= 1'b1;
                                    r_eop   <= w_next_last;
                                end
`else
                                r_valid <= 1'b1;
                                r_eop   <= w_next_last;
`endif
                            end
                        end else begin
                            // Backpressure: hold the beat as presented.
                            r_valid <= 1'b1;
                        end
                    end else begin
                        // End of an idle cycle: re-present the pending beat.
                        r_valid <= 1'b1;
                        r_eop   <= w_last;
                    end
                end

                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_sop   <= 1'b0;
                    r_eop   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign st_data       = r_data;
    assign valid         = r_valid;
    assign startofpacket = r_sop;
    assign endofpacket   = r_eop;
    assign busy          = r_busy;
    assign done          = r_done;
    assign beats_sent    = r_beats_sent;

endmodule

// File: tb/tb_test_st_source.sv
module tb_test_st_source;

    localparam int DW = 256;
    localparam int CW = 16;
    localparam int W  = DW / 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_beats;
    logic [31:0]   seed;
    logic [DW-1:0] st_data;
    logic          valid;
    logic          ready;
    logic          startofpacket;
    logic          endofpacket;
    logic          busy;
    logic          done;
    logic [CW-1:0] beats_sent;

    int vectors     = 0;
    int miscompares = 0;

    test_st_source #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_beats     (num_beats),
        .seed          (seed),
        .st_data       (st_data),
        .valid         (valid),
        .ready         (ready),
        .startofpacket (startofpacket),
        .endofpacket   (endofpacket),
        .busy          (busy),
        .done          (done),
        .beats_sent    (beats_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference beat: word j of beat k is seed + k*W + j, wrapping at 2^32.
    function automatic logic [DW-1:0] ref_beat(input logic [31:0] s, input int k);
        logic [DW-1:0] v;
        logic [31:0]   word;
        v = {DW{1'b0}};
        for (int j = 0; j < W; j++) begin
            word = s + 32'(k * W) + 32'(j);
            v[32*j +: 32] = word;
        end
        return v;
    endfunction

    // One packet checked cycle by cycle against a handshake-count model.
    // mode 0: ready=1, mode 1: random ready, mode 2: 3 stall cycles on beat 1.
    // Call 1 time unit after a posedge while the DUT is idle.
    task automatic run_packet(input int n, input logic [31:0] s, input int mode, input bit poke);
        int hs;
        int stalls;
        bit bubble;
        bit nb;
        bit ev;
        bit rdy;
        bit fin;
        num_beats = CW'(n);
        seed      = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        num_beats = CW'($urandom);
        seed      = $urandom;
        hs = 0; stalls = 0; bubble = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < n * 3 + 40 && !fin; cyc++) begin
            start = 1'b0;
            if (hs == n) begin
                chk("done_pulse", DW'(done), DW'(1'b1));
                chk("valid_fin", DW'(valid), DW'(1'b0));
                chk("busy_fin", DW'(busy), DW'(1'b1));
                if (n != 0) chk("sent_fin", DW'(beats_sent), DW'(n));
                fin = 1'b1;
            end else begin
                ev = !bubble;
                chk("valid", DW'(valid), DW'(ev));
                chk("busy", DW'(busy), DW'(1'b1));
                chk("done_low", DW'(done), DW'(1'b0));
                chk("beats_sent", DW'(beats_sent), DW'(hs));
                chk("sop", DW'(startofpacket), DW'(ev && hs == 0));
                chk("eop", DW'(endofpacket), DW'(ev && hs == n - 1));
                if (ev) chk("data", st_data, ref_beat(s, hs));
                if (ev && hs == 0 && s == 32'hFFFF_FFFF)
                    chk("wrap_word1", DW'(st_data[63:32]), DW'(32'h0000_0000));
                case (mode)
                    1: rdy = ($urandom_range(0, 3) != 0);
                    2: begin
                        if (hs == 1 && stalls < 3) begin
                            rdy = 1'b0;
                            stalls++;
                        end else begin
                            rdy = 1'b1;
                        end
                    end
                    default: rdy = 1'b1;
                endcase
                ready = rdy;
                if (poke && cyc == 1) begin
                    start     = 1'b1;
                    num_beats = CW'($urandom_range(1, 50));
                    seed      = $urandom;
                end
                nb = 1'b0;
                if (ev && rdy) begin
`ifdef ST_SRC_BUBBLE_EN
                    if (hs % 4 == 3 && hs != n - 1) nb = 1'b1;
`endif
                    hs++;
                end
                bubble = nb;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!fin) chk("timeout", DW'(1'b0), DW'(1'b1));
        chk("idle_done", DW'(done), DW'(1'b0));
        chk("idle_busy", DW'(busy), DW'(1'b0));
        chk("idle_valid", DW'(valid), DW'(1'b0));
        if (n != 0) chk("sent_hold", DW'(beats_sent), DW'(n));
        ready = 1'b1;
    endtask

    initial begin
        logic [31:0] rs;
        rst = 1'b0; start = 1'b0; ready = 1'b1;
        num_beats = {CW{1'b0}}; seed = 32'd0;
        #2;
        chk("rst_valid", DW'(valid), DW'(1'b0));
        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_done", DW'(done), DW'(1'b0));
        chk("rst_sop", DW'(startofpacket), DW'(1'b0));
        chk("rst_eop", DW'(endofpacket), DW'(1'b0));
        chk("rst_sent", DW'(beats_sent), DW'(1'b0));
        chk("rst_data", st_data, {DW{1'b0}});
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_packet(1, 32'h0000_0000, 0, 1'b0);
        run_packet(4, 32'h0000_0100, 0, 1'b0);
        run_packet(5, $urandom, 2, 1'b0);
        run_packet(0, $urandom, 0, 1'b0);
        run_packet(6, $urandom, 0, 1'b1);
        run_packet(2, 32'hFFFF_FFFF, 0, 1'b0);
        run_packet(8, $urandom, 0, 1'b0);

        // Reset in the middle of a packet, while beat 2 is presented.
        rs = $urandom;
        num_beats = CW'(6); seed = rs; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_sent", DW'(beats_sent), DW'(2));
        chk("pre_rst_data", st_data, ref_beat(rs, 2));
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", DW'(valid), DW'(1'b0));
        chk("midrst_busy", DW'(busy), DW'(1'b0));
        chk("midrst_sent", DW'(beats_sent), DW'(1'b0));
        chk("midrst_sop", DW'(startofpacket), DW'(1'b0));
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("postrst_valid", DW'(valid), DW'(1'b0));
        run_packet(3, $urandom, 0, 1'b0);

        // Randomized packets with random backpressure.
        for (int i = 0; i < 12; i++) begin
            run_packet($urandom_range(1, 20), $urandom, 1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
